mips_multicycle_core: RTL
=========================

Name: mips_multicycle_core

Overview:
Parametrised multi-cycle successor to the single-cycle MIPS datapath. The core shares one memory port between instruction fetch and data access, and that port uses a req/ready handshake so wait-state memories can be attached. A control FSM sequences each instruction over 3–5 cycles. The core adds vectored interrupt entry and return (EPC/ERET), which the single-cycle design lacks. It sits between the board-level top (debounced clock, display decoders) and an external unified memory.

Parameters:
ADDR_W, 16, word-address width of the PC and memory port; must be ≤ 26.
RESET_PC, 0, PC value loaded on reset.
IRQ_VECTOR, 16'h0080, PC value loaded on interrupt entry.

Ports:
clock  in  1  core clock.
n_reset  in  1  asynchronous active-low reset.
interrupt  in  1  level-sensitive interrupt request.
mem_req  out  1  memory access request.
mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
mem_addr  out  ADDR_W  word address.
mem_wdata  out  32  store data.
mem_rdata  in  32  read data; valid in the cycle mem_ready = 1.
mem_ready  in  1  access completes on the rising edge where mem_req & mem_ready.
pc  out  ADDR_W  address of the current instruction, for display.
alu_result  out  32  last registered ALU output, for display.
state  out  3  FSM state encoding, for debug LEDs.
instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
illegal  out  1  one-cycle pulse when DECODE sees an unsupported opcode.

Behaviour:
- Reset (async, n_reset = 0):
  - pc = RESET_PC, state = FETCH.
  - All 32 registers, IR, A, B, ALUOut, MDR, EPC = 0; ie = 1.
  - mem_req, mem_we, instr_done, illegal = 0; mem_addr = RESET_PC; alu_result = 0.
  - Reset asserted mid-access drops mem_req immediately; no register or memory write completes.
- Word addressing: PC+1 is the next instruction. Branch target = PC+1+sext(imm16), truncated to ADDR_W. Jump target = instr[ADDR_W-1:0].
- Register $0 reads 0; writes to it are discarded.
- Supported instructions:
  - R-type (op 0): add, sub, and, or, slt (funct 20, 22, 24, 25, 2A hex).
  - addi (08), lw (23), sw (2B), beq (04), j (02).
  - eret (op 10, funct 18).
  - Any other op or funct: treated as a NOP, illegal pulses, next state FETCH.
- FSM states: FETCH, DECODE, EXEC, MEM, WB.
  - FETCH: mem_req = 1, mem_we = 0, mem_addr = PC. Holds until mem_ready, then latches IR and goes to DECODE.
  - DECODE: latches A = rs and B = rt, and computes the branch target.
    - j: PC ← target, done.
    - eret: PC ← EPC, ie ← 1, done.
    - beq: PC ← A == B ? target : PC+1, done.
    - Otherwise go to EXEC.
  - EXEC: computes ALUOut.
    - R-type / addi → WB.
    - lw / sw → MEM (address = ALUOut[ADDR_W-1:0]).
  - MEM: mem_req = 1; mem_we = 1 for sw with mem_wdata = B. Holds until mem_ready.
    - sw: done.
    - lw: latches MDR → WB.
  - WB: writes rd (R-type), rt (addi), or MDR into rt (lw); done.
- "Done" means:
  - instr_done pulses.
  - PC ← next PC (PC+1 unless redirected).
  - state → FETCH.
- Cycle counts with zero-wait memory: j, beq, eret = 2; sw = 4; R-type, addi = 4; lw = 5. Each wait cycle (mem_req high, mem_ready low) adds exactly one cycle.
- Handshake rules:
  - mem_addr, mem_we and mem_wdata stay stable while mem_req is high and mem_ready is low.
  - mem_req deasserts in the cycle after acceptance.
  - mem_ready while mem_req = 0 is ignored.
- Interrupts: sampled only in a done cycle.
  - If interrupt & ie: EPC ← next PC, ie ← 0, PC ← IRQ_VECTOR.
  - An instruction is never aborted part-way.
  - eret completing while interrupt is still high re-enters at the vector immediately; EPC = the eret's restored PC.
- slt is a signed comparison. add/addi wrap modulo 2^32; no overflow trap.

Decomposition:
- Shared package mips_pkg holds:
  - opcode and funct localparams.
  - The FSM state enum (3-bit).
  - ALU operation codes.
- Sub-module mips_regfile: 32×32, two async read ports, one sync write port, $0 hardwired to 0.
- The ALU is reused inline.

Test Plan:
- Reset release, memory with zero wait states, mem[0] = addi $1,$0,5 → fetch at addr 0; instr_done after 4 cycles; alu_result = 5; pc = 1.
- lw $2,0($1) with mem[5] = 32'hDEADBEEF and mem_ready delayed 3 cycles in MEM → address 5 stays stable; $2 = DEADBEEF; instruction takes 8 cycles total.
- beq $1,$1,-1 at addr 3 → pc returns to 3 after 2 cycles; taken-branch loop repeats.
- interrupt raised during EXEC of an add at addr 7 → add completes; EPC = 8; pc = 16'h0080. A later eret → pc = 8 and ie = 1.
- Illegal op 6'h3F at addr 2 → illegal pulses once; no register or memory write; next fetch at addr 3.
- n_reset asserted during a sw MEM wait → mem_req drops asynchronously, no write occurs, pc = RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared opcode/funct encodings, FSM state and ALU operation types for the
// multi-cycle MIPS core.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_COP0  = 6'h10;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ERET  = 6'h18;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4
   } state_e;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_SLT = 3'd4
   } alu_op_e;

   function automatic alu_op_e funct_to_alu(input logic [5:0] funct);
      case (funct)
         FN_SUB:  return ALU_SUB;
         FN_AND:  return ALU_AND;
         FN_OR:   return ALU_OR;
         FN_SLT:  return ALU_SLT;
         default: return ALU_ADD;
      endcase
   endfunction

   // Add/sub wrap modulo 2^32; slt compares as signed.
   function automatic logic [31:0] alu_calc(input alu_op_e op, input logic [31:0] a,
                                            input logic [31:0] b);
      case (op)
         ALU_SUB: return a - b;
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_SLT: return {31'd0, ($signed(a) < $signed(b))};
         default: return a + b;
      endcase
   endfunction

endpackage

// File: rtl/mips_mem_if.sv
// Unified instruction/data memory port with a req/ready handshake; the core
// is the master, the external memory is the slave.
interface mips_mem_if #(
   parameter int ADDR_W = 16
) ();

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              mem_ready;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );

endinterface

// File: rtl/mips_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port, register $0 hardwired to zero.
module mips_regfile (
   input  logic        clock,
   input  logic        n_reset,
   input  logic [4:0]  i_rs_addr,
   input  logic [4:0]  i_rt_addr,
   output logic [31:0] o_rs_data,
   output logic [31:0] o_rt_data,
   input  logic        i_we,
   input  logic [4:0]  i_wr_addr,
   input  logic [31:0] i_wr_data
);

   logic [31:0] r_regs [0:31];

   // NOTE: the array is reset because every register is architecturally zero
   // after reset; that forces a flop implementation rather than a RAM.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         for (int i = 0; i < 32; i++) r_regs[i] <= '0;
      end else if (i_we && (i_wr_addr != 5'd0)) begin
         r_regs[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rs_data = r_regs[i_rs_addr];
   assign o_rt_data = r_regs[i_rt_addr];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core: FETCH/DECODE/EXEC/MEM/WB sequencing over one shared
// req/ready memory port, with vectored interrupt entry and eret.
module mips_multicycle_core
   import mips_pkg::*;
#(
   parameter int                ADDR_W     = 16,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0,
   parameter logic [ADDR_W-1:0] IRQ_VECTOR = ADDR_W'(16'h0080)
) (
   input  logic              clock,
   input  logic              n_reset,
   input  logic              interrupt,
   mips_mem_if.master        mem,
   output logic [ADDR_W-1:0] pc,
   output logic [31:0]       alu_result,
   output logic [2:0]        state,
   output logic              instr_done,
   output logic              illegal
);

   state_e            r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_epc;
   logic              r_ie;
   logic [31:0]       r_ir;
   logic [31:0]       r_a;
   logic [31:0]       r_b;
   logic [31:0]       r_alu_out;
   logic [31:0]       r_mdr;

   logic [5:0]        w_op;
   logic [5:0]        w_funct;
   logic [4:0]        w_rs;
   logic [4:0]        w_rt;
   logic [4:0]        w_rd;
   logic [31:0]       w_imm_sext;
   logic [31:0]       w_rs_data;
   logic [31:0]       w_rt_data;
   logic              w_rtype_ok;
   logic              w_is_eret;
   logic              w_legal;
   logic [ADDR_W-1:0] w_pc_inc;
   logic [ADDR_W-1:0] w_br_target;
   logic [ADDR_W-1:0] w_pc_next;
   logic              w_done;
   logic              w_ie_set;
   logic              w_take_irq;
   alu_op_e           w_alu_op;
   logic [31:0]       w_alu_b;
   logic              w_rf_we;
   logic [4:0]        w_rf_waddr;
   logic [31:0]       w_rf_wdata;

   assign w_op       = r_ir[31:26];
   assign w_rs       = r_ir[25:21];
   assign w_rt       = r_ir[20:16];
   assign w_rd       = r_ir[15:11];
   assign w_funct    = r_ir[5:0];
   assign w_imm_sext = {{16{r_ir[15]}}, r_ir[15:0]};

   assign w_rtype_ok = (w_op == OP_RTYPE) &&
                       ((w_funct == FN_ADD) || (w_funct == FN_SUB) || (w_funct == FN_AND) ||
                        (w_funct == FN_OR)  || (w_funct == FN_SLT));
   assign w_is_eret  = (w_op == OP_COP0) && (w_funct == FN_ERET);
   assign w_legal    = w_rtype_ok || w_is_eret || (w_op == OP_ADDI) || (w_op == OP_LW) ||
                       (w_op == OP_SW) || (w_op == OP_BEQ) || (w_op == OP_J);

   // Truncating the sign-extended offset before the add gives the same
   // ADDR_W-bit result as adding at full width and truncating afterwards.
   assign w_pc_inc    = r_pc + ADDR_W'(1);
   assign w_br_target = w_pc_inc + w_imm_sext[ADDR_W-1:0];

   // NOTE: every output of this block gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      w_done    = 1'b0;
      w_ie_set  = 1'b0;
      w_pc_next = w_pc_inc;
      case (r_state)
         ST_DECODE: begin
            if (!w_legal) begin
               w_done = 1'b1;
            end else if (w_op == OP_J) begin
               w_done    = 1'b1;
               w_pc_next = r_ir[ADDR_W-1:0];
            end else if (w_is_eret) begin
               w_done    = 1'b1;
               w_ie_set  = 1'b1;
               w_pc_next = r_epc;
            end else if (w_op == OP_BEQ) begin
               w_done    = 1'b1;
               w_pc_next = (w_rs_data == w_rt_data) ? w_br_target : w_pc_inc;
            end
         end
         ST_MEM:  w_done = mem.mem_ready && (w_op == OP_SW);
         ST_WB:   w_done = 1'b1;
         default: w_done = 1'b0;
      endcase
   end

   // An eret re-enables interrupts in the same cycle it samples them, so a
   // still-pending request re-enters the vector at once.
   assign w_take_irq = w_done && interrupt && (r_ie || w_ie_set);

   assign w_alu_op = (w_op == OP_RTYPE) ? funct_to_alu(w_funct) : ALU_ADD;
   assign w_alu_b  = (w_op == OP_RTYPE) ? r_b : w_imm_sext;

   // NOTE: all state below uses non-blocking assignments so every register
   // samples the pre-edge values; the done block relies on overriding the
   // per-state next-state assignment made earlier in the same edge.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         r_state   <= ST_FETCH;
         r_pc      <= RESET_PC;
         r_epc     <= '0;
         r_ie      <= 1'b1;
         r_ir      <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_alu_out <= '0;
         r_mdr     <= '0;
      end else begin
         case (r_state)
            ST_FETCH: begin
               if (mem.mem_ready) begin
                  r_ir    <= mem.mem_rdata;
                  r_state <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               r_a     <= w_rs_data;
               r_b     <= w_rt_data;
               r_state <= ST_EXEC;
            end
            ST_EXEC: begin
               r_alu_out <= alu_calc(w_alu_op, r_a, w_alu_b);
               r_state   <= ((w_op == OP_LW) || (w_op == OP_SW)) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
               if (mem.mem_ready && (w_op == OP_LW)) begin
                  r_mdr   <= mem.mem_rdata;
                  r_state <= ST_WB;
               end
            end
            default: ;
         endcase

         if (w_done) begin
            r_state <= ST_FETCH;
            if (w_take_irq) begin
               r_pc  <= IRQ_VECTOR;
               r_epc <= w_pc_next;
               r_ie  <= 1'b0;
            end else begin
               r_pc <= w_pc_next;
               if (w_ie_set) r_ie <= 1'b1;
            end
         end
      end
   end

   assign w_rf_we    = (r_state == ST_WB);
   assign w_rf_waddr = (w_op == OP_RTYPE) ? w_rd : w_rt;
   assign w_rf_wdata = (w_op == OP_LW) ? r_mdr : r_alu_out;

   mips_regfile u_regfile (
      .clock     (clock),
      .n_reset   (n_reset),
      .i_rs_addr (w_rs),
      .i_rt_addr (w_rt),
      .o_rs_data (w_rs_data),
      .o_rt_data (w_rt_data),
      .i_we      (w_rf_we),
      .i_wr_addr (w_rf_waddr),
      .i_wr_data (w_rf_wdata)
   );

   // Gating with n_reset drops the request the instant reset asserts.
   assign mem.mem_req   = n_reset && ((r_state == ST_FETCH) || (r_state == ST_MEM));
   assign mem.mem_we    = (r_state == ST_MEM) && (w_op == OP_SW);
   assign mem.mem_addr  = (r_state == ST_MEM) ? r_alu_out[ADDR_W-1:0] : r_pc;
   assign mem.mem_wdata = r_b;

   assign pc         = r_pc;
   assign alu_result = r_alu_out;
   assign state      = r_state;
   assign instr_done = w_done;
   assign illegal    = (r_state == ST_DECODE) && !w_legal;

endmodule
